mm_stream_sched: RTL and testbench

Synthesizable sequencer that feeds the `mm` matrix-multiply core from on-chip A/B operand memories and collects its results into a D memory. On `start` it latches a job configuration, then:
- streams A frames and B frames as AXI-Stream with correct `tlast` framing;
- writes every result word to D;
- pulses `done` when the last result frame has arrived.

It sits between the host-side buffers and `mm`, replacing the bench-side streaming drivers in hardware builds.

---
 rtl/mm_sched_pkg.sv | 18 +
 rtl/mm_stream_src.sv | 88 ++++++++
 rtl/mm_stream_sched.sv | 194 +++++++++++++++++++
 tb/tb_mm_stream_sched.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_sched_pkg.sv
// Shared types and helpers for the mm_stream_sched sequencer.
package mm_sched_pkg;

  localparam int AXIS_W = 32;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} sched_state_t;

  // Sign-extend the low 'width' bits of raw across the whole stream word.
  function automatic logic [AXIS_W-1:0] sext_stream(input logic [AXIS_W-1:0] raw,
                                                    input logic [5:0] width);
    logic [AXIS_W-1:0] mask;
    logic sign;
    mask = {AXIS_W{1'b1}} << width;
    sign = raw[5'(width - 6'd1)];
    return sign ? (raw | mask) : (raw & ~mask);
  endfunction

endpackage

// File: rtl/mm_stream_src.sv
// One operand source: linear memory reader feeding an AXI-Stream through a
// 2-entry skid FIFO, with per-frame tlast and an exhausted flag.
module mm_stream_src
  import mm_sched_pkg::*;
#(
  parameter int D_W    = 8,
  parameter int ADDR_W = 16,
  parameter int FRM_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              active,
  input  logic [ADDR_W-1:0] cfg_words,
  input  logic [FRM_W-1:0]  cfg_frames,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [D_W-1:0]    rd_data,
  output logic              tvalid,
  output logic [AXIS_W-1:0] tdata,
  output logic              tlast,
  input  logic              tready,
  output logic              exhausted
);

  localparam int CNT_W = ADDR_W + FRM_W;

  logic [ADDR_W-1:0] words_reg;
  logic [ADDR_W-1:0] word_reg;
  logic [CNT_W-1:0]  total_reg;
  logic [CNT_W-1:0]  issued_reg;
  logic              inflight_reg;
  logic [1:0]        count_reg;
  logic              wr_ptr_reg;
  logic              rd_ptr_reg;
  logic [D_W-1:0]    mem_reg [2];

  logic [D_W-1:0] head;
  logic           pop;
  logic           fifo_pop;
  logic           push;

  // The beat returning from memory this cycle is presented directly when the
  // FIFO is empty, so the first beat appears one cycle after its read.
  assign rd_en     = active && (issued_reg != total_reg) &&
                     (({1'b0, count_reg} + {2'b00, inflight_reg}) < 3'd2);
  assign rd_addr   = issued_reg[ADDR_W-1:0];
  assign tvalid    = (count_reg != 2'd0) || inflight_reg;
  assign head      = (count_reg != 2'd0) ? mem_reg[rd_ptr_reg] : rd_data;
  assign tdata     = tvalid ? sext_stream(AXIS_W'(head), 6'(D_W)) : '0;
  assign tlast     = tvalid && (word_reg == words_reg - ADDR_W'(1));
  assign pop       = tvalid && tready;
  assign fifo_pop  = pop && (count_reg != 2'd0);
  assign push      = inflight_reg && !((count_reg == 2'd0) && tready);
  assign exhausted = (issued_reg == total_reg) && (count_reg == 2'd0) && !inflight_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      words_reg    <= '0;
      word_reg     <= '0;
      total_reg    <= '0;
      issued_reg   <= '0;
      inflight_reg <= 1'b0;
      count_reg    <= 2'd0;
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
    end else begin
      inflight_reg <= rd_en;
      count_reg    <= count_reg + {1'b0, push} - {1'b0, fifo_pop};
      if (push)     wr_ptr_reg <= ~wr_ptr_reg;
      if (fifo_pop) rd_ptr_reg <= ~rd_ptr_reg;
      if (load) begin
        words_reg  <= cfg_words;
        total_reg  <= CNT_W'(cfg_words) * CNT_W'(cfg_frames);
        issued_reg <= '0;
        word_reg   <= '0;
      end else begin
        if (rd_en) issued_reg <= issued_reg + CNT_W'(1);
        if (pop)   word_reg   <= tlast ? '0 : word_reg + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_reg[wr_ptr_reg] <= rd_data;
  end

endmodule

// File: rtl/mm_stream_sched.sv
// Job sequencer around the mm core: streams A/B operands, collects D results.
// Optional performance counters are enabled by defining MM_SCHED_PERF_EN.
module mm_stream_sched
  import mm_sched_pkg::*;
#(
  parameter int D_W     = 8,
  parameter int D_W_ACC = 32,
  parameter int ADDR_W  = 16,
  parameter int FRM_W   = 8
) (
  input  logic                mm_clk,
  input  logic                mm_rst,
  input  logic                start,
  input  logic [ADDR_W-1:0]   cfg_a_words,
  input  logic [ADDR_W-1:0]   cfg_b_words,
  input  logic [ADDR_W-1:0]   cfg_d_words,
  input  logic [FRM_W-1:0]    cfg_a_frames,
  input  logic [FRM_W-1:0]    cfg_b_frames,
  output logic                busy,
  output logic                done,
  output logic                err_frame,
  output logic                a_rd_en,
  output logic [ADDR_W-1:0]   a_rd_addr,
  input  logic [D_W-1:0]      a_rd_data,
  output logic                b_rd_en,
  output logic [ADDR_W-1:0]   b_rd_addr,
  input  logic [D_W-1:0]      b_rd_data,
  output logic                m_axis_a_tvalid,
  output logic [AXIS_W-1:0]   m_axis_a_tdata,
  output logic                m_axis_a_tlast,
  input  logic                m_axis_a_tready,
  output logic                m_axis_b_tvalid,
  output logic [AXIS_W-1:0]   m_axis_b_tdata,
  output logic                m_axis_b_tlast,
  input  logic                m_axis_b_tready,
  input  logic                s_axis_d_tvalid,
  input  logic [AXIS_W-1:0]   s_axis_d_tdata,
  input  logic                s_axis_d_tlast,
  output logic                s_axis_d_tready,
  output logic                d_wr_en,
  output logic [ADDR_W-1:0]   d_wr_addr,
  output logic [D_W_ACC-1:0]  d_wr_data
`ifdef MM_SCHED_PERF_EN
  ,
  output logic [31:0]         perf_cycles,
  output logic [31:0]         perf_a_stall,
  output logic [31:0]         perf_b_stall
`endif
);

  sched_state_t state_reg, state_next;

  logic              launch;
  logic [ADDR_W-1:0] d_words_reg;
  logic [FRM_W-1:0]  b_frames_reg;
  logic [ADDR_W-1:0] d_addr_reg;
  logic [ADDR_W-1:0] d_word_reg;
  logic [FRM_W-1:0]  d_frames_reg;
  logic              d_accept;

  // Index 0 is the A source, index 1 the B source.
  logic [1:0][ADDR_W-1:0] src_words;
  logic [1:0][FRM_W-1:0]  src_frames;
  logic [1:0][ADDR_W-1:0] src_addr;
  logic [1:0][D_W-1:0]    src_rd_data;
  logic [1:0][AXIS_W-1:0] src_tdata;
  logic [1:0]             src_rd_en, src_tvalid, src_tlast, src_tready, src_exh;

  assign launch = start && (state_reg == IDLE);

  assign src_words   = {cfg_b_words, cfg_a_words};
  assign src_frames  = {cfg_b_frames, cfg_a_frames};
  assign src_rd_data = {b_rd_data, a_rd_data};
  assign src_tready  = {m_axis_b_tready, m_axis_a_tready};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      mm_stream_src #(.D_W(D_W), .ADDR_W(ADDR_W), .FRM_W(FRM_W)) u_src (
        .clk       (mm_clk),
        .rst       (mm_rst),
        .load      (launch),
        .active    (busy),
        .cfg_words (src_words[gi]),
        .cfg_frames(src_frames[gi]),
        .rd_en     (src_rd_en[gi]),
        .rd_addr   (src_addr[gi]),
        .rd_data   (src_rd_data[gi]),
        .tvalid    (src_tvalid[gi]),
        .tdata     (src_tdata[gi]),
        .tlast     (src_tlast[gi]),
        .tready    (src_tready[gi]),
        .exhausted (src_exh[gi])
      );
    end
  endgenerate

  assign a_rd_en         = src_rd_en[0];
  assign a_rd_addr       = src_addr[0];
  assign m_axis_a_tvalid = src_tvalid[0];
  assign m_axis_a_tdata  = src_tdata[0];
  assign m_axis_a_tlast  = src_tlast[0];
  assign b_rd_en         = src_rd_en[1];
  assign b_rd_addr       = src_addr[1];
  assign m_axis_b_tvalid = src_tvalid[1];
  assign m_axis_b_tdata  = src_tdata[1];
  assign m_axis_b_tlast  = src_tlast[1];

  always_ff @(posedge mm_clk or posedge mm_rst) begin
    if (mm_rst) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    busy       = 1'b0;
    done       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (launch)
          state_next = ((cfg_a_frames == '0) && (cfg_b_frames == '0)) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if ((&src_exh) && (d_frames_reg == b_frames_reg)) state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign s_axis_d_tready = busy;
  assign d_accept        = s_axis_d_tvalid && busy;

  // A misplaced tlast still closes the frame so later frames realign.
  always_ff @(posedge mm_clk or posedge mm_rst) begin
    if (mm_rst) begin
      d_wr_en      <= 1'b0;
      d_wr_addr    <= '0;
      d_wr_data    <= '0;
      err_frame    <= 1'b0;
      d_words_reg  <= '0;
      b_frames_reg <= '0;
      d_addr_reg   <= '0;
      d_word_reg   <= '0;
      d_frames_reg <= '0;
    end else begin
      d_wr_en <= d_accept;
      if (launch) begin
        err_frame    <= 1'b0;
        d_words_reg  <= cfg_d_words;
        b_frames_reg <= cfg_b_frames;
        d_addr_reg   <= '0;
        d_word_reg   <= '0;
        d_frames_reg <= '0;
      end else if (d_accept) begin
        d_wr_addr  <= d_addr_reg;
        d_wr_data  <= s_axis_d_tdata[D_W_ACC-1:0];
        d_addr_reg <= d_addr_reg + ADDR_W'(1);
        if (s_axis_d_tlast) begin
          d_word_reg   <= '0;
          d_frames_reg <= d_frames_reg + FRM_W'(1);
          if (d_word_reg != d_words_reg - ADDR_W'(1)) err_frame <= 1'b1;
        end else begin
          d_word_reg <= d_word_reg + ADDR_W'(1);
        end
      end
    end
  end

`ifdef MM_SCHED_PERF_EN
  always_ff @(posedge mm_clk or posedge mm_rst) begin
    if (mm_rst) begin
      perf_cycles  <= '0;
      perf_a_stall <= '0;
      perf_b_stall <= '0;
    end else if (launch) begin
      perf_cycles  <= '0;
      perf_a_stall <= '0;
      perf_b_stall <= '0;
    end else if (busy) begin
      if (perf_cycles != '1) perf_cycles <= perf_cycles + 32'd1;
      if (m_axis_a_tvalid && !m_axis_a_tready && (perf_a_stall != '1))
        perf_a_stall <= perf_a_stall + 32'd1;
      if (m_axis_b_tvalid && !m_axis_b_tready && (perf_b_stall != '1))
        perf_b_stall <= perf_b_stall + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mm_stream_sched.sv
// Scoreboard bench for mm_stream_sched: memory models, A/B sinks, D source.
module tb_mm_stream_sched;

  localparam int D_W = 8, D_W_ACC = 32, ADDR_W = 16, FRM_W = 8;

  logic mm_clk = 1'b0;
  logic mm_rst = 1'b1;
  logic start = 1'b0;
  logic [ADDR_W-1:0] cfg_a_words = '0, cfg_b_words = '0, cfg_d_words = '0;
  logic [FRM_W-1:0]  cfg_a_frames = '0, cfg_b_frames = '0;
  logic busy, done, err_frame;
  logic a_rd_en, b_rd_en;
  logic [ADDR_W-1:0] a_rd_addr, b_rd_addr;
  logic [D_W-1:0] a_rd_data, b_rd_data;
  logic m_axis_a_tvalid, m_axis_a_tlast, m_axis_b_tvalid, m_axis_b_tlast;
  logic [31:0] m_axis_a_tdata, m_axis_b_tdata;
  logic m_axis_a_tready = 1'b1, m_axis_b_tready = 1'b1;
  logic s_axis_d_tvalid = 1'b0, s_axis_d_tlast = 1'b0;
  logic [31:0] s_axis_d_tdata = '0;
  logic s_axis_d_tready;
  logic d_wr_en;
  logic [ADDR_W-1:0] d_wr_addr;
  logic [D_W_ACC-1:0] d_wr_data;
`ifdef MM_SCHED_PERF_EN
  logic [31:0] perf_cycles, perf_a_stall, perf_b_stall;
`endif

  mm_stream_sched #(.D_W(D_W), .D_W_ACC(D_W_ACC), .ADDR_W(ADDR_W), .FRM_W(FRM_W)) dut (
    .mm_clk(mm_clk), .mm_rst(mm_rst), .start(start),
    .cfg_a_words(cfg_a_words), .cfg_b_words(cfg_b_words), .cfg_d_words(cfg_d_words),
    .cfg_a_frames(cfg_a_frames), .cfg_b_frames(cfg_b_frames),
    .busy(busy), .done(done), .err_frame(err_frame),
    .a_rd_en(a_rd_en), .a_rd_addr(a_rd_addr), .a_rd_data(a_rd_data),
    .b_rd_en(b_rd_en), .b_rd_addr(b_rd_addr), .b_rd_data(b_rd_data),
    .m_axis_a_tvalid(m_axis_a_tvalid), .m_axis_a_tdata(m_axis_a_tdata),
    .m_axis_a_tlast(m_axis_a_tlast), .m_axis_a_tready(m_axis_a_tready),
    .m_axis_b_tvalid(m_axis_b_tvalid), .m_axis_b_tdata(m_axis_b_tdata),
    .m_axis_b_tlast(m_axis_b_tlast), .m_axis_b_tready(m_axis_b_tready),
    .s_axis_d_tvalid(s_axis_d_tvalid), .s_axis_d_tdata(s_axis_d_tdata),
    .s_axis_d_tlast(s_axis_d_tlast), .s_axis_d_tready(s_axis_d_tready),
    .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_wr_data(d_wr_data)
`ifdef MM_SCHED_PERF_EN
    , .perf_cycles(perf_cycles), .perf_a_stall(perf_a_stall), .perf_b_stall(perf_b_stall)
`endif
  );

  always #5 mm_clk = ~mm_clk;

  logic [7:0] a_mem [256];
  logic [7:0] b_mem [256];

  always @(posedge mm_clk) begin
    if (a_rd_en) a_rd_data <= a_mem[a_rd_addr[7:0]];
    if (b_rd_en) b_rd_data <= b_mem[b_rd_addr[7:0]];
  end

  logic [32:0] a_exp[$], b_exp[$], d_src[$];
  logic [47:0] d_exp[$];

  int total = 0, bad = 0, cyc = 0;
  int stall_pct = 0;
  int start_cyc, a_beats, b_beats, d_writes, done_cnt, done_cyc, busy_rise, busy_cnt;
  int first_rd, first_tv, last_a_cyc, last_d_cyc, err_rise, rd_cnt, tv_cnt;
  int a_stalls, b_stalls, d_addr_exp;
  logic busy_at_done;
  logic [ADDR_W-1:0] first_rd_addr, last_wr_addr;
  logic pa_v, pa_r, pb_v, pb_r;
  logic [32:0] pa_d, pb_d;

  function automatic logic [31:0] sx(input logic [7:0] v);
    return {{24{v[7]}}, v};
  endfunction

  task automatic clear_track();
    a_exp.delete(); b_exp.delete(); d_src.delete(); d_exp.delete();
    a_beats = 0; b_beats = 0; d_writes = 0; done_cnt = 0; done_cyc = -1;
    busy_rise = -1; busy_cnt = 0; first_rd = -1; first_tv = -1; last_a_cyc = -1;
    last_d_cyc = -1; err_rise = -1; rd_cnt = 0; tv_cnt = 0; a_stalls = 0; b_stalls = 0;
    d_addr_exp = 0; busy_at_done = 1'b0; first_rd_addr = '1; last_wr_addr = '0;
    pa_v = 0; pa_r = 0; pb_v = 0; pb_r = 0; pa_d = '0; pb_d = '0;
  endtask

  task automatic build_streams(input int aw, input int af, input int bw, input int bf);
    for (int i = 0; i < aw * af; i++) a_exp.push_back({(i % aw) == aw - 1, sx(a_mem[i])});
    for (int i = 0; i < bw * bf; i++) b_exp.push_back({(i % bw) == bw - 1, sx(b_mem[i])});
  endtask

  // Called at a falling edge: observe this cycle, drive inputs for the next rising edge.
  task automatic step();
    logic [32:0] e;
    logic [47:0] w;
    if (busy) begin busy_cnt++; if (busy_rise < 0) busy_rise = cyc; end
    if (a_rd_en) begin rd_cnt++; if (first_rd < 0) begin first_rd = cyc; first_rd_addr = a_rd_addr; end end
    if (b_rd_en) rd_cnt++;
    if (m_axis_a_tvalid) begin tv_cnt++; if (first_tv < 0) first_tv = cyc; end
    if (m_axis_b_tvalid) tv_cnt++;
    if (done) begin done_cnt++; done_cyc = cyc; busy_at_done = busy; end
    if (err_frame && err_rise < 0) err_rise = cyc;
    if (d_wr_en) begin
      d_writes++; total++; last_wr_addr = d_wr_addr;
      if (d_exp.size() == 0) begin
        bad++; $display("FAIL d_write unexpected got addr=%0d data=%h", d_wr_addr, d_wr_data);
      end else begin
        w = d_exp.pop_front();
        if ({d_wr_addr, d_wr_data} !== w) begin
          bad++; $display("FAIL d_write got=%h exp=%h", {d_wr_addr, d_wr_data}, w);
        end
      end
    end
    if (pa_v && !pa_r) begin
      total++;
      if ({m_axis_a_tvalid, m_axis_a_tlast, m_axis_a_tdata} !== {1'b1, pa_d}) begin
        bad++; $display("FAIL a_hold got=%h exp=%h", {m_axis_a_tvalid, m_axis_a_tlast, m_axis_a_tdata}, {1'b1, pa_d});
      end
    end
    if (pb_v && !pb_r) begin
      total++;
      if ({m_axis_b_tvalid, m_axis_b_tlast, m_axis_b_tdata} !== {1'b1, pb_d}) begin
        bad++; $display("FAIL b_hold got=%h exp=%h", {m_axis_b_tvalid, m_axis_b_tlast, m_axis_b_tdata}, {1'b1, pb_d});
      end
    end
    m_axis_a_tready = int'($urandom_range(99)) >= stall_pct;
    m_axis_b_tready = int'($urandom_range(99)) >= stall_pct;
    if (m_axis_a_tvalid && !m_axis_a_tready) a_stalls++;
    if (m_axis_b_tvalid && !m_axis_b_tready) b_stalls++;
    if (m_axis_a_tvalid && m_axis_a_tready) begin
      a_beats++; total++; last_a_cyc = cyc;
      if (a_exp.size() == 0) begin
        bad++; $display("FAIL a_beat unexpected got=%h", {m_axis_a_tlast, m_axis_a_tdata});
      end else begin
        e = a_exp.pop_front();
        if ({m_axis_a_tlast, m_axis_a_tdata} !== e) begin
          bad++; $display("FAIL a_beat %0d got=%h exp=%h", a_beats - 1, {m_axis_a_tlast, m_axis_a_tdata}, e);
        end
      end
    end
    if (m_axis_b_tvalid && m_axis_b_tready) begin
      b_beats++; total++;
      if (b_exp.size() == 0) begin
        bad++; $display("FAIL b_beat unexpected got=%h", {m_axis_b_tlast, m_axis_b_tdata});
      end else begin
        e = b_exp.pop_front();
        if ({m_axis_b_tlast, m_axis_b_tdata} !== e) begin
          bad++; $display("FAIL b_beat %0d got=%h exp=%h", b_beats - 1, {m_axis_b_tlast, m_axis_b_tdata}, e);
        end
      end
    end
    pa_v = m_axis_a_tvalid; pa_r = m_axis_a_tready; pa_d = {m_axis_a_tlast, m_axis_a_tdata};
    pb_v = m_axis_b_tvalid; pb_r = m_axis_b_tready; pb_d = {m_axis_b_tlast, m_axis_b_tdata};
    // Results are released only once every operand beat has been consumed.
    s_axis_d_tvalid = 1'b0;
    if (d_src.size() > 0 && a_exp.size() == 0 && b_exp.size() == 0) begin
      e = d_src[0];
      s_axis_d_tvalid = 1'b1;
      {s_axis_d_tlast, s_axis_d_tdata} = e;
      if (s_axis_d_tready) begin
        void'(d_src.pop_front());
        d_exp.push_back({16'(d_addr_exp), e[31:0]});
        d_addr_exp++;
        last_d_cyc = cyc;
      end
    end
    @(negedge mm_clk);
    cyc++;
  endtask

  task automatic do_start(input int aw, input int af, input int bw, input int bf, input int dw);
    cfg_a_words = 16'(aw); cfg_a_frames = 8'(af);
    cfg_b_words = 16'(bw); cfg_b_frames = 8'(bf);
    cfg_d_words = 16'(dw);
    start = 1'b1;
    start_cyc = cyc;
    step();
    start = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin step(); n++; end
    total++;
    if (done_cnt == 0) begin bad++; $display("FAIL done_timeout got=none exp=pulse within %0d cycles", budget); end
    repeat (3) step();
  endtask

  task automatic test_reset();
    total++;
    if ({busy, done, err_frame, a_rd_en, b_rd_en, m_axis_a_tvalid, m_axis_b_tvalid, s_axis_d_tready,
         d_wr_en, m_axis_a_tlast, m_axis_b_tlast, a_rd_addr, b_rd_addr, d_wr_addr, d_wr_data,
         m_axis_a_tdata, m_axis_b_tdata} !== '0) begin
      bad++; $display("FAIL reset_outputs got busy=%b done=%b err=%b a_rd=%b tv=%b%b wr=%b exp all zero",
                      busy, done, err_frame, a_rd_en, m_axis_a_tvalid, m_axis_b_tvalid, d_wr_en);
    end
  endtask

  task automatic test_single();
    logic signed [7:0] av, bv;
    int sum;
    clear_track();
    stall_pct = 0;
    build_streams(64, 1, 64, 1);
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 8; j++) begin
        sum = 0;
        for (int k = 0; k < 8; k++) begin
          av = a_mem[i * 8 + k]; bv = b_mem[k * 8 + j];
          sum += int'(av) * int'(bv);
        end
        d_src.push_back({(i * 8 + j) == 63, 32'(sum)});
      end
    do_start(64, 1, 64, 1, 64);
    run_until_done(600);
    total++; if (a_beats != 64 || b_beats != 64) begin bad++; $display("FAIL single_beats got a=%0d b=%0d exp 64", a_beats, b_beats); end
    total++; if (d_writes != 64) begin bad++; $display("FAIL single_writes got=%0d exp=64", d_writes); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL single_done_count got=%0d exp=1", done_cnt); end
    total++; if (err_frame !== 1'b0) begin bad++; $display("FAIL single_err got=%b exp=0", err_frame); end
    total++; if (busy_rise != start_cyc + 1) begin bad++; $display("FAIL busy_rise got=%0d exp=%0d", busy_rise, start_cyc + 1); end
    total++; if (first_rd != start_cyc + 1) begin bad++; $display("FAIL first_rd got=%0d exp=%0d", first_rd, start_cyc + 1); end
    total++; if (first_tv != start_cyc + 2) begin bad++; $display("FAIL first_tvalid got=%0d exp=%0d", first_tv, start_cyc + 2); end
    total++; if (last_a_cyc != first_tv + 63) begin bad++; $display("FAIL a_throughput got=%0d exp=%0d", last_a_cyc, first_tv + 63); end
    total++; if (done_cyc != last_d_cyc + 2) begin bad++; $display("FAIL done_timing got=%0d exp=%0d", done_cyc, last_d_cyc + 2); end
    total++; if (busy_at_done !== 1'b0) begin bad++; $display("FAIL busy_at_done got=%b exp=0", busy_at_done); end
    total++; if (a_exp.size() + b_exp.size() + d_exp.size() + d_src.size() != 0) begin
      bad++; $display("FAIL single_leftover got=%0d exp=0", a_exp.size() + b_exp.size() + d_exp.size() + d_src.size());
    end
  endtask

  task automatic test_reuse(input int pct);
    clear_track();
    stall_pct = pct;
    build_streams(16, 2, 16, 4);
    for (int i = 0; i < 64; i++) d_src.push_back({(i % 16) == 15, 32'($urandom)});
    do_start(16, 2, 16, 4, 16);
    run_until_done(2000);
    total++; if (a_beats != 32 || b_beats != 64) begin bad++; $display("FAIL reuse_beats pct=%0d got a=%0d b=%0d exp a=32 b=64", pct, a_beats, b_beats); end
    total++; if (d_writes != 64 || last_wr_addr != 16'd63) begin bad++; $display("FAIL reuse_d pct=%0d got n=%0d last=%0d exp n=64 last=63", pct, d_writes, last_wr_addr); end
    total++; if (done_cnt != 1 || done_cyc != last_d_cyc + 2) begin bad++; $display("FAIL reuse_done pct=%0d got n=%0d cyc=%0d exp n=1 cyc=%0d", pct, done_cnt, done_cyc, last_d_cyc + 2); end
    total++; if (a_exp.size() + b_exp.size() + d_exp.size() != 0) begin bad++; $display("FAIL reuse_leftover pct=%0d got=%0d exp=0", pct, a_exp.size() + b_exp.size() + d_exp.size()); end
    if (pct == 0) begin
      total++; if (last_a_cyc != first_tv + 31) begin bad++; $display("FAIL reuse_no_bubble got=%0d exp=%0d", last_a_cyc, first_tv + 31); end
    end
`ifdef MM_SCHED_PERF_EN
    total++;
    if (perf_a_stall != 32'(a_stalls) || perf_b_stall != 32'(b_stalls) || perf_cycles != 32'(busy_cnt)) begin
      bad++; $display("FAIL perf got=%0d/%0d/%0d exp=%0d/%0d/%0d", perf_cycles, perf_a_stall, perf_b_stall, busy_cnt, a_stalls, b_stalls);
    end
`endif
    stall_pct = 0;
  endtask

  task automatic test_misframe();
    clear_track();
    build_streams(16, 1, 16, 1);
    for (int i = 0; i < 10; i++) d_src.push_back({i == 9, 32'h100 + 32'(i)});
    do_start(16, 1, 16, 1, 16);
    run_until_done(400);
    total++; if (err_rise != last_d_cyc + 1) begin bad++; $display("FAIL err_rise got=%0d exp=%0d", err_rise, last_d_cyc + 1); end
    total++; if (err_frame !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_frame); end
    total++; if (d_writes != 10 || done_cnt != 1) begin bad++; $display("FAIL misframe_job got wr=%0d done=%0d exp wr=10 done=1", d_writes, done_cnt); end
  endtask

  task automatic test_zero();
    clear_track();
    d_src.push_back({1'b1, 32'h0000_1234});
    do_start(16, 0, 16, 0, 16);
    total++; if (done !== 1'b1) begin bad++; $display("FAIL zero_done got=%b exp=1", done); end
    total++; if (err_frame !== 1'b0) begin bad++; $display("FAIL err_clear got=%b exp=0", err_frame); end
    repeat (6) step();
    total++; if (done_cnt != 1 || done_cyc != start_cyc + 1) begin bad++; $display("FAIL zero_done_timing got n=%0d cyc=%0d exp n=1 cyc=%0d", done_cnt, done_cyc, start_cyc + 1); end
    total++; if (rd_cnt != 0 || tv_cnt != 0 || d_writes != 0) begin bad++; $display("FAIL zero_activity got rd=%0d tv=%0d wr=%0d exp 0", rd_cnt, tv_cnt, d_writes); end
    d_src.delete();
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_track();
    build_streams(64, 1, 64, 1);
    do_start(64, 1, 64, 1, 64);
    while (a_beats < 20 && n < 200) begin step(); n++; end
    total++; if (a_beats < 20) begin bad++; $display("FAIL mid_progress got=%0d exp=20", a_beats); end
    mm_rst = 1'b1;
    #1;
    test_reset();
    @(negedge mm_clk); cyc++;
    mm_rst = 1'b0;
    @(negedge mm_clk); cyc++;
    clear_track();
    build_streams(64, 1, 64, 1);
    for (int i = 0; i < 64; i++) d_src.push_back({i == 63, 32'hA000 + 32'(i)});
    do_start(64, 1, 64, 1, 64);
    run_until_done(600);
    total++; if (first_rd_addr != 16'd0) begin bad++; $display("FAIL restart_addr got=%0d exp=0", first_rd_addr); end
    total++; if (a_beats != 64 || b_beats != 64 || d_writes != 64 || done_cnt != 1) begin
      bad++; $display("FAIL restart_job got a=%0d b=%0d wr=%0d done=%0d exp 64/64/64/1", a_beats, b_beats, d_writes, done_cnt);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin a_mem[i] = 8'($urandom); b_mem[i] = 8'($urandom); end
    clear_track();
    repeat (2) @(negedge mm_clk);
    test_reset();
    mm_rst = 1'b0;
    @(negedge mm_clk); cyc++;
    test_single();
    test_reuse(0);
    test_reuse(30);
    test_misframe();
    test_zero();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
